debounce_bank: RTL and testbench
================================

# debounce_bank

Multi-channel debouncer with edge and long-press reporting, the parametrised successor to the single-bit debouncer. It sits between board buttons/switches and the fabric (FSMs, traffic-light controller). All channels share one tick prescaler. Per channel it provides a filtered level, one-cycle rise/fall strobes and an optional long-press strobe.

## Interface
- C_CLK_FRQ, 100_000_000: clock frequency [Hz].
- C_TICK_US, 100: tick period [µs]; C_PRESCALE = C_CLK_FRQ/1_000_000*C_TICK_US, must be an integer ≥ 2.
- C_CHANNELS, 4: number of independent inputs, ≥ 1.
- C_STABLE, 100: ticks an input must stay stable before it is accepted (default 10 ms), ≥ 1.
- C_LONG, 10_000: ticks of accepted high level before the long-press strobe fires (default 1 s), ≥ 1.
- clk  input  1  master clock.
- rstb  input  1  reset: synchronous, active-low.
- in  input  C_CHANNELS  raw asynchronous switch/button levels.
- out  output  C_CHANNELS  debounced levels (registered).
- rise  output  C_CHANNELS  one-cycle strobe when out goes 0→1.
- fall  output  C_CHANNELS  one-cycle strobe when out goes 1→0.
- long  output  C_CHANNELS  one-cycle long-press strobe (constant 0 when the feature is compiled out).

## Operation
- Prescaler: a counter of width $clog2(C_PRESCALE) wraps at C_PRESCALE-1. On wrap, tick = 1 for exactly one cycle.
- Per channel, the input passes through a 2-FF synchroniser (s1 → s2).
- Stable counter cnt, width $clog2(C_STABLE+1):
  - If s2 == out, cnt is cleared to 0 every cycle. This rejects glitches: any return to the accepted level restarts the wait.
  - If s2 != out and tick: when cnt == C_STABLE-1, out ← s2 and cnt ← 0; otherwise cnt ← cnt+1.
  - If s2 != out and no tick: cnt holds.
- rise/fall: asserted in the same cycle out changes, for that cycle only. rise and fall are never both high on one channel.
- Long press (feature enabled):
  - Counter lcnt, width $clog2(C_LONG+1), is cleared while out == 0.
  - While out == 1, lcnt increments on each tick, saturating at C_LONG.
  - long pulses for one cycle on the tick where lcnt goes C_LONG-1 → C_LONG. There is no auto-repeat; it re-arms only after out returns to 0.
- Channels are fully independent. Simultaneous changes on several channels are all handled in the same cycles.

## Timing
- Reset: all of the following go to 0 on the first clk edge with rstb = 0: prescaler, s1, s2, cnt, lcnt, out, rise, fall, long.
- Reset mid-operation: out drops to 0 with no fall strobe, and pending counts are lost.
- First tick occurs C_PRESCALE cycles after rstb is released.
- Accept latency from an in edge held stable: 2 synchroniser cycles + C_STABLE ticks. This is between (C_STABLE-1)*C_PRESCALE+3 and C_STABLE*C_PRESCALE+2 cycles, depending on prescaler phase.
- A pulse shorter than (C_STABLE-1)*C_PRESCALE cycles is always rejected.
- long fires C_LONG ticks (±1 tick of phase) after the rise strobe.
- All outputs are registered; there are no combinational paths from in to any output.

## Configuration
- DEBOUNCE_BANK_LONG_EN defined: lcnt registers and long-press logic are built as specified.
- DEBOUNCE_BANK_LONG_EN undefined: no lcnt registers are built. The long port remains, tied to 0. All other behaviour is identical.

## Structure
- The shared package debounce_pkg holds:
  - the prescale derivation function (C_CLK_FRQ, C_TICK_US → cycles);
  - the width helper for counters;
  - default constants (100 µs tick, 10 ms stable, 1 s long).
- One sub-module, debounce_channel: synchroniser, cnt, out register, rise/fall logic, and lcnt/long when enabled. It is instantiated C_CHANNELS times in a generate loop. The top level holds only the prescaler and the port slicing.

## Test plan
Bench parameters: C_CLK_FRQ=10_000_000, C_TICK_US=1 (C_PRESCALE=10), C_CHANNELS=4, C_STABLE=4, C_LONG=20; macro defined unless stated.
- Reset: drive in=4'hF with rstb=0 for 5 cycles → out, rise, fall and long all 0 throughout.
- Clean press: in[0] 0→1 and held → out[0]=1 within 33..42 cycles, with rise[0] high for exactly that one cycle; other channels unchanged.
- Glitch rejection: in[1] high for 25 cycles, then low → out[1] stays 0, no strobes. Repeat with bounce (5 on/5 off ×6, then steady high) → exactly one rise[1], within 42 cycles after the final steady edge.
- Release and simultaneity: in[2] and in[3] fall in the same cycle after being accepted high → fall[2] and fall[3] strobe in the same cycle.
- Long press: hold in[0] high → long[0] pulses once, 20 ticks (±1) after rise[0]. Holding a further 500 cycles gives no second pulse. Release and re-press → long[0] fires again. With the macro undefined → long stays 0.
- Reset mid-count: assert rstb while in[0] has been high for 2 ticks → out=0, no strobes. After release, acceptance takes a full 33..42 cycles again.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and sizing helpers for the debouncer bank and its channels.
package debounce_pkg;

  localparam int C_DEF_CLK_FRQ = 100_000_000;
  localparam int C_DEF_TICK_US = 100;
  localparam int C_DEF_STABLE  = 100;
  localparam int C_DEF_LONG    = 10_000;

  // Clock cycles per tick for a given clock frequency [Hz] and tick period [us].
  function automatic int prescale(input int clk_frq, input int tick_us);
    return clk_frq / 1_000_000 * tick_us;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Raw inputs and filtered outputs of a debouncer bank, one bit per channel.
interface debounce_bank_if #(
  parameter int C_CHANNELS = 4
) ();

  logic [C_CHANNELS-1:0] in;
  logic [C_CHANNELS-1:0] out;
  logic [C_CHANNELS-1:0] rise;
  logic [C_CHANNELS-1:0] fall;
  logic [C_CHANNELS-1:0] long;

  modport master (output in, input out, rise, fall, long);
  modport slave  (input in, output out, rise, fall, long);

endinterface

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability counter, edge strobes and,
// when DEBOUNCE_BANK_LONG_EN is defined, the long-press counter and strobe.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int C_STABLE = C_DEF_STABLE
`ifdef DEBOUNCE_BANK_LONG_EN
  , parameter int C_LONG = C_DEF_LONG
`endif
) (
  input  logic clk,
  input  logic rstb,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic long
);

  localparam int CW = cnt_width(C_STABLE + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(C_STABLE - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic [CW-1:0] cnt_reg;
  logic          out_reg;
  logic          rise_reg;
  logic          fall_reg;

  // Any return to the accepted level clears cnt, so glitches restart the wait.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      cnt_reg  <= '0;
      out_reg  <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      s1_reg   <= in;
      s2_reg   <= s1_reg;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (s2_reg == out_reg) begin
        cnt_reg <= '0;
      end else if (tick) begin
        if (cnt_reg == STABLE_LAST) begin
          out_reg  <= s2_reg;
          cnt_reg  <= '0;
          rise_reg <= s2_reg;
          fall_reg <= ~s2_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign out  = out_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

`ifdef DEBOUNCE_BANK_LONG_EN
  localparam int LW = cnt_width(C_LONG + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(C_LONG);
  localparam logic [LW-1:0] LONG_LAST = LW'(C_LONG - 1);

  logic [LW-1:0] lcnt_reg;
  logic          long_reg;

  // Saturation at LONG_MAX is what prevents auto-repeat until out drops.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      lcnt_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      long_reg <= 1'b0;
      if (!out_reg) begin
        lcnt_reg <= '0;
      end else if (tick && (lcnt_reg != LONG_MAX)) begin
        lcnt_reg <= lcnt_reg + 1'b1;
        long_reg <= (lcnt_reg == LONG_LAST);
      end
    end
  end

  assign long = long_reg;
`else
  assign long = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: one shared tick prescaler feeding C_CHANNELS
// debounce_channel instances. Long-press logic is built with DEBOUNCE_BANK_LONG_EN.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int C_CLK_FRQ  = C_DEF_CLK_FRQ,
  parameter int C_TICK_US  = C_DEF_TICK_US,
  parameter int C_CHANNELS = 4,
  parameter int C_STABLE   = C_DEF_STABLE,
  parameter int C_LONG     = C_DEF_LONG
) (
  input logic           clk,
  input logic           rstb,
  debounce_bank_if.slave bus
);

  localparam int C_PRESCALE = prescale(C_CLK_FRQ, C_TICK_US);
  localparam int PW = cnt_width(C_PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(C_PRESCALE - 1);
  localparam bit CFG_OK = (C_PRESCALE >= 2) && (C_CHANNELS >= 1) &&
                          (C_STABLE >= 1) && (C_LONG >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("debounce_bank: need C_PRESCALE>=2 and C_CHANNELS, C_STABLE, C_LONG >= 1");
  end

  logic [PW-1:0] pre_reg;
  logic          tick_reg;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      pre_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (pre_reg == PRE_LAST);
      pre_reg  <= (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
    end
  end

  logic [C_CHANNELS-1:0] out_vec;
  logic [C_CHANNELS-1:0] rise_vec;
  logic [C_CHANNELS-1:0] fall_vec;
  logic [C_CHANNELS-1:0] long_vec;

  for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_ch
    debounce_channel #(
      .C_STABLE(C_STABLE)
`ifdef DEBOUNCE_BANK_LONG_EN
      , .C_LONG(C_LONG)
`endif
    ) u_ch (
      .clk  (clk),
      .rstb (rstb),
      .tick (tick_reg),
      .in   (bus.in[gi]),
      .out  (out_vec[gi]),
      .rise (rise_vec[gi]),
      .fall (fall_vec[gi]),
      .long (long_vec[gi])
    );
  end

  assign bus.out  = out_vec;
  assign bus.rise = rise_vec;
  assign bus.fall = fall_vec;
  assign bus.long = long_vec;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: tests queue expected strobes with cycle
// windows, a negedge monitor pops and compares every strobe the DUT emits.
`timescale 1ns/1ps
module tb_debounce_bank;

  localparam int N       = 4;
  localparam int P       = 10;
  localparam int S       = 4;
  localparam int L       = 20;
  localparam int ACC_MIN = (S - 1) * P + 3;
  localparam int ACC_MAX = S * P + 2;
`ifdef DEBOUNCE_BANK_LONG_EN
  localparam int LONG_ON = 1;
`else
  localparam int LONG_ON = 0;
`endif

  typedef enum int {EV_RISE, EV_FALL, EV_LONG} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       ch;
    int       lo;
    int       hi;
  } ev_t;

  logic clk  = 1'b0;
  logic rstb = 1'b0;

  debounce_bank_if #(.C_CHANNELS(N)) bus ();

  debounce_bank #(
    .C_CLK_FRQ (10_000_000),
    .C_TICK_US (1),
    .C_CHANNELS(N),
    .C_STABLE  (S),
    .C_LONG    (L)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  last_rise[N];
  int  last_fall[N];
  int  last_long[N];
  int  long_cnt[N];

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic     hit;
    ev_kind_t kind;
    ev_t      e;
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < 3; k++) begin
        kind = ev_kind_t'(k);
        case (k)
          0:       hit = (bus.rise[c] === 1'b1);
          1:       hit = (bus.fall[c] === 1'b1);
          default: hit = (bus.long[c] === 1'b1);
        endcase
        if (hit) begin
          case (k)
            0:       last_rise[c] = cyc;
            1:       last_fall[c] = cyc;
            default: begin last_long[c] = cyc; long_cnt[c]++; end
          endcase
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got %s ch%0d at cycle %0d, required no strobe",
                     kind.name(), c, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.ch != c || cyc < e.lo || cyc > e.hi) begin
              errors++;
              $display("FAIL strobe_match: got %s ch%0d at cycle %0d, required %s ch%0d in cycles %0d..%0d",
                       kind.name(), c, cyc, e.kind.name(), e.ch, e.lo, e.hi);
            end else begin
              $display("ok   %s ch%0d at cycle %0d (window %0d..%0d)", kind.name(), c, cyc, e.lo, e.hi);
            end
          end
        end
      end
    end
  end

  task automatic push_ev(input ev_kind_t k, input int ch, input int lo, input int hi);
    ev_t e;
    e.kind = k;
    e.ch   = ch;
    e.lo   = lo;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  // Waits for the queue to empty within a cycle budget, then lets late strobes surface.
  task automatic drain(input int budget, output int left);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    left = exp_q.size();
    exp_q.delete();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rstb   = 1'b0;
    bus.in = '1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({bus.out, bus.rise, bus.fall, bus.long} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: out=%b rise=%b fall=%b long=%b, required all 0",
                 bus.out, bus.rise, bus.fall, bus.long);
      end
    end
    bus.in = '0;
    @(negedge clk);
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: out=%b, required 0000", bus.out);
    end
  endtask

  task automatic test_clean_press();
    int left;
    push_ev(EV_RISE, 0, cyc + ACC_MIN, cyc + ACC_MAX);
    bus.in[0] = 1'b1;
    drain(60, left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL press_timeout: pending=%0d, required 0", left);
    end
    checks++;
    if (bus.out !== 4'b0001) begin
      errors++;
      $display("FAIL press_out: out=%b, required 0001", bus.out);
    end
    push_ev(EV_FALL, 0, cyc + ACC_MIN, cyc + ACC_MAX);
    bus.in[0] = 1'b0;
    drain(60, left);
    checks++;
    if (left !== 0 || bus.out !== 4'b0000) begin
      errors++;
      $display("FAIL release_out: pending=%0d out=%b, required 0 and 0000", left, bus.out);
    end
  endtask

  task automatic test_glitch();
    int left;
    bus.in[1] = 1'b1;
    repeat (25) @(negedge clk);
    bus.in[1] = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (bus.out !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_out: out=%b, required 0000", bus.out);
    end
    repeat (6) begin
      bus.in[1] = 1'b1;
      repeat (5) @(negedge clk);
      bus.in[1] = 1'b0;
      repeat (5) @(negedge clk);
    end
    push_ev(EV_RISE, 1, cyc + ACC_MIN, cyc + ACC_MAX);
    bus.in[1] = 1'b1;
    drain(60, left);
    checks++;
    if (left !== 0 || bus.out !== 4'b0010) begin
      errors++;
      $display("FAIL bounce_out: pending=%0d out=%b, required 0 and 0010", left, bus.out);
    end
    push_ev(EV_FALL, 1, cyc + ACC_MIN, cyc + ACC_MAX);
    bus.in[1] = 1'b0;
    drain(60, left);
    checks++;
    if (left !== 0 || bus.out !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_release: pending=%0d out=%b, required 0 and 0000", left, bus.out);
    end
  endtask

  task automatic test_back_to_back();
    int left;
    push_ev(EV_RISE, 2, cyc + ACC_MIN, cyc + ACC_MAX);
    push_ev(EV_RISE, 3, cyc + ACC_MIN, cyc + ACC_MAX);
    bus.in[3:2] = 2'b11;
    drain(60, left);
    checks++;
    if (left !== 0 || bus.out !== 4'b1100 || last_rise[2] !== last_rise[3]) begin
      errors++;
      $display("FAIL simul_rise: pending=%0d out=%b rise cycles %0d/%0d, required 0, 1100, equal",
               left, bus.out, last_rise[2], last_rise[3]);
    end
    push_ev(EV_FALL, 2, cyc + ACC_MIN, cyc + ACC_MAX);
    push_ev(EV_FALL, 3, cyc + ACC_MIN, cyc + ACC_MAX);
    bus.in[3:2] = 2'b00;
    drain(60, left);
    checks++;
    if (left !== 0 || bus.out !== 4'b0000 || last_fall[2] !== last_fall[3]) begin
      errors++;
      $display("FAIL simul_fall: pending=%0d out=%b fall cycles %0d/%0d, required 0, 0000, equal",
               left, bus.out, last_fall[2], last_fall[3]);
    end
  endtask

  task automatic test_long_press();
    int left;
    int base;
    base = long_cnt[0];
    for (int round = 1; round <= 2; round++) begin
      push_ev(EV_RISE, 0, cyc + ACC_MIN, cyc + ACC_MAX);
`ifdef DEBOUNCE_BANK_LONG_EN
      push_ev(EV_LONG, 0, cyc + ACC_MIN + (L - 1) * P, cyc + ACC_MAX + (L + 1) * P);
`endif
      bus.in[0] = 1'b1;
      drain(300, left);
      checks++;
      if (left !== 0) begin
        errors++;
        $display("FAIL long_timeout: round %0d pending=%0d, required 0", round, left);
      end
`ifdef DEBOUNCE_BANK_LONG_EN
      checks++;
      if (last_long[0] - last_rise[0] < (L - 1) * P || last_long[0] - last_rise[0] > (L + 1) * P) begin
        errors++;
        $display("FAIL long_delay: round %0d delay=%0d cycles, required %0d..%0d",
                 round, last_long[0] - last_rise[0], (L - 1) * P, (L + 1) * P);
      end
`endif
      repeat (500) @(negedge clk);
      checks++;
      if (long_cnt[0] - base !== round * LONG_ON || bus.out !== 4'b0001) begin
        errors++;
        $display("FAIL long_count: round %0d pulses=%0d out=%b, required %0d and 0001",
                 round, long_cnt[0] - base, bus.out, round * LONG_ON);
      end
      push_ev(EV_FALL, 0, cyc + ACC_MIN, cyc + ACC_MAX);
      bus.in[0] = 1'b0;
      drain(60, left);
      checks++;
      if (left !== 0 || bus.out !== 4'b0000) begin
        errors++;
        $display("FAIL long_release: round %0d pending=%0d out=%b, required 0 and 0000",
                 round, left, bus.out);
      end
    end
  endtask

  task automatic test_reset_mid();
    int left;
    bus.in[0] = 1'b1;
    repeat (22) @(negedge clk);
    rstb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.out, bus.rise, bus.fall, bus.long} !== '0) begin
        errors++;
        $display("FAIL midreset_outputs: out=%b rise=%b fall=%b, required all 0",
                 bus.out, bus.rise, bus.fall);
      end
    end
    rstb = 1'b1;
    push_ev(EV_RISE, 0, cyc + ACC_MIN, cyc + ACC_MAX);
    drain(60, left);
    checks++;
    if (left !== 0 || bus.out !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_reaccept: pending=%0d out=%b, required 0 and 0001", left, bus.out);
    end
    rstb = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_accepted: out=%b, required 0000", bus.out);
    end
    bus.in[0] = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (bus.out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_quiet: out=%b, required 0000", bus.out);
    end
  endtask

  initial begin
    bus.in = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_back_to_back();
    test_long_press();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
